fwd_scoreboard: RTL and testbench



---
 rtl/fwd_scoreboard_if.sv | 44 ++++
 rtl/fwd_scoreboard.sv | 117 +++++++++++
 tb/tb_fwd_scoreboard.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_scoreboard_if.sv
// Signal bundle between pipeline control and the in-flight write scoreboard.
// master = pipeline/hazard side driving requests, slave = scoreboard.
interface fwd_scoreboard_if #(
   parameter int NUM_REGS = 8,
   parameter int DEPTH    = 3,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 16
);
   localparam int REG_W = $clog2(NUM_REGS);
   localparam int SEL_W = $clog2(DEPTH);

   logic                    advance;
   logic                    flush;
   logic                    id_valid;
   logic                    id_wr;
   logic [REG_W-1:0]        id_dest;
   logic [SEL_W-1:0]        id_lat;
   logic [REG_W-1:0]        ex_src1;
   logic [REG_W-1:0]        ex_src2;
   logic                    ex_use1;
   logic                    ex_use2;
   logic [DEPTH*DATA_W-1:0] stage_data;
   logic [SEL_W-1:0]        fwd1_sel;
   logic [SEL_W-1:0]        fwd2_sel;
   logic [DATA_W-1:0]       fwd1_data;
   logic [DATA_W-1:0]       fwd2_data;
   logic                    stall;
   logic [CNT_W-1:0]        stall_cycles;
   logic [CNT_W-1:0]        fwd_events;

   modport master (
      output advance, flush, id_valid, id_wr, id_dest, id_lat,
             ex_src1, ex_src2, ex_use1, ex_use2, stage_data,
      input  fwd1_sel, fwd2_sel, fwd1_data, fwd2_data, stall,
             stall_cycles, fwd_events
   );

   modport slave (
      input  advance, flush, id_valid, id_wr, id_dest, id_lat,
             ex_src1, ex_src2, ex_use1, ex_use2, stage_data,
      output fwd1_sel, fwd2_sel, fwd1_data, fwd2_data, stall,
             stall_cycles, fwd_events
   );
endinterface

// File: rtl/fwd_scoreboard.sv
// In-flight write scoreboard and operand forwarding selector.
// Entry 0 is the instruction in EX; entry DEPTH-1 is the last stage before
// regfile write. Each entry remembers the first index at which its result
// may be forwarded; a younger consumer that finds it earlier is stalled.
module fwd_scoreboard #(
   parameter int NUM_REGS = 8,
   parameter int DEPTH    = 3,
   parameter int DATA_W   = 16,
   parameter int CNT_W    = 16
) (
   input logic             clk,
   input logic             rst,
   fwd_scoreboard_if.slave bus
);
   localparam int REG_W = $clog2(NUM_REGS);
   localparam int SEL_W = $clog2(DEPTH);

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] dest;
      logic [SEL_W-1:0] lat;   // first entry index where the result is forwardable
   } entry_t;

   typedef struct packed {
      logic             hit;
      logic             ready;
      logic [SEL_W-1:0] idx;
   } lookup_t;

   entry_t [DEPTH-1:0] ent_q;
   lookup_t            look1;
   lookup_t            look2;
   logic               stall_c;
   logic [SEL_W-1:0]   sel1;
   logic [SEL_W-1:0]   sel2;
   logic [DATA_W-1:0]  data1;
   logic [DATA_W-1:0]  data2;
   logic [SEL_W-1:0]   id_lat_eff;
   logic [CNT_W-1:0]   stall_cnt_q;
   logic [CNT_W-1:0]   fwd_cnt_q;

   // Youngest valid producer of src among entries 1..DEPTH-1. The scan runs
   // oldest to youngest so the lowest-index match is the one that sticks.
   function automatic lookup_t find_youngest(input entry_t [DEPTH-1:0] ents,
                                             input logic [REG_W-1:0]   src,
                                             input logic               rd);
      lookup_t res;
      res = '0;
      for (int k = DEPTH-1; k >= 1; k--) begin
         if (rd && ents[k].valid && ents[k].dest == src) begin
            res.hit   = 1'b1;
            res.idx   = SEL_W'(k);
            res.ready = (SEL_W'(k) >= ents[k].lat);
         end
      end
      return res;
   endfunction

   // A latency of 0 means the same as 1: nothing is forwardable from entry 0.
   assign id_lat_eff = (bus.id_lat == '0) ? SEL_W'(1) : bus.id_lat;

   // Resolve both EX sources against in-flight entries; drive muxes and stall.
   always_comb begin
      // NOTE: every signal written here gets a default first so no latch is inferred.
      sel1  = '0;
      sel2  = '0;
      data1 = '0;
      data2 = '0;
      look1 = find_youngest(ent_q, bus.ex_src1, bus.ex_use1);
      look2 = find_youngest(ent_q, bus.ex_src2, bus.ex_use2);
      if (look1.hit && look1.ready) sel1 = look1.idx;
      if (look2.hit && look2.ready) sel2 = look2.idx;
      if (sel1 != '0) data1 = bus.stage_data[int'(sel1)*DATA_W +: DATA_W];
      if (sel2 != '0) data2 = bus.stage_data[int'(sel2)*DATA_W +: DATA_W];
      stall_c = (look1.hit && !look1.ready) || (look2.hit && !look2.ready);
   end

   // Move entries down the pipeline; a stall holds EX and injects a bubble.
   always_ff @(posedge clk) begin
      // NOTE: only valid bits are reset; dest/lat are don't-care while invalid.
      if (rst || bus.flush) begin
         for (int k = 0; k < DEPTH; k++) ent_q[k].valid <= 1'b0;
      end else if (bus.advance) begin
         // NOTE: non-blocking so every entry takes its neighbour's pre-edge value.
         for (int k = DEPTH-1; k >= 2; k--) ent_q[k] <= ent_q[k-1];
         if (stall_c) begin
            ent_q[1].valid <= 1'b0;
         end else begin
            ent_q[1] <= ent_q[0];
            ent_q[0] <= '{valid: bus.id_valid & bus.id_wr,
                          dest:  bus.id_dest,
                          lat:   id_lat_eff};
         end
      end
   end

   // Saturating performance counters; flush leaves them untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         fwd_cnt_q   <= '0;
      end else begin
         if (bus.advance && stall_c && !bus.flush && stall_cnt_q != '1)
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
         if (bus.advance && !stall_c && (sel1 != '0 || sel2 != '0) && fwd_cnt_q != '1)
            fwd_cnt_q <= fwd_cnt_q + CNT_W'(1);
      end
   end

   assign bus.fwd1_sel     = sel1;
   assign bus.fwd2_sel     = sel2;
   assign bus.fwd1_data    = data1;
   assign bus.fwd2_data    = data2;
   assign bus.stall        = stall_c;
   assign bus.stall_cycles = stall_cnt_q;
   assign bus.fwd_events   = fwd_cnt_q;
endmodule

// File: tb/tb_fwd_scoreboard.sv
// Bench for fwd_scoreboard: directed cycle table, random run against a
// queue-based pipeline model, and a counter saturation / reset-in-stall case
// on a deep narrow-counter instance.
module tb_fwd_scoreboard;
   localparam int NUM_REGS = 8;
   localparam int DEPTH    = 3;
   localparam int DATA_W   = 16;
   localparam int CNT_W    = 16;
   localparam int REG_W    = $clog2(NUM_REGS);
   localparam int SEL_W    = $clog2(DEPTH);
   localparam int S_DEPTH  = 32;
   localparam int S_CNT_W  = 4;
   localparam int S_SEL_W  = $clog2(S_DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fwd_scoreboard_if #(.NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
   fwd_scoreboard_if #(.NUM_REGS(NUM_REGS), .DEPTH(S_DEPTH), .DATA_W(DATA_W), .CNT_W(S_CNT_W)) sbus ();

   fwd_scoreboard #(.NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .DATA_W(DATA_W), .CNT_W(CNT_W))
      dut (.clk(clk), .rst(rst), .bus(bus));
   fwd_scoreboard #(.NUM_REGS(NUM_REGS), .DEPTH(S_DEPTH), .DATA_W(DATA_W), .CNT_W(S_CNT_W))
      dut_s (.clk(clk), .rst(rst), .bus(sbus));

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // ---------------- directed cycle table ----------------
   typedef struct {
      int adv, fl, idv, idw, dest, lat;
      int s1, u1, s2, u2;
      int e1, e2, es, esc, efe;
   } vec_t;
   vec_t vecs[$];

   function automatic vec_t mk(input int adv, fl, idv, idw, dest, lat,
                               s1, u1, s2, u2, e1, e2, es, esc, efe);
      vec_t v;
      v = '{adv, fl, idv, idw, dest, lat, s1, u1, s2, u2, e1, e2, es, esc, efe};
      return v;
   endfunction

   logic [DATA_W-1:0] sd [DEPTH];

   task automatic pack_sd();
      for (int k = 0; k < DEPTH; k++) bus.stage_data[k*DATA_W +: DATA_W] = sd[k];
   endtask

   task automatic drive(input vec_t v);
      bus.advance  = 1'(v.adv);
      bus.flush    = 1'(v.fl);
      bus.id_valid = 1'(v.idv);
      bus.id_wr    = 1'(v.idw);
      bus.id_dest  = REG_W'(v.dest);
      bus.id_lat   = SEL_W'(v.lat);
      bus.ex_src1  = REG_W'(v.s1);
      bus.ex_use1  = 1'(v.u1);
      bus.ex_src2  = REG_W'(v.s2);
      bus.ex_use2  = 1'(v.u2);
   endtask

   task automatic idle_all();
      drive(mk(0,0,0,0,0,1, 0,0,0,0, 0,0,0,0,0));
      sbus.advance = 1'b0; sbus.flush = 1'b0; sbus.id_valid = 1'b0; sbus.id_wr = 1'b0;
      sbus.id_dest = '0; sbus.id_lat = S_SEL_W'(1);
      sbus.ex_src1 = '0; sbus.ex_src2 = '0; sbus.ex_use1 = 1'b0; sbus.ex_use2 = 1'b0;
      sbus.stage_data = '0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- reference model ----------------
   // pipe[0] is the EX instruction, pipe[i] is i stages past EX.
   typedef struct { bit valid; int dest; int lat; } m_ent_t;
   m_ent_t pipe[$];
   int m_sc, m_fe;

   function automatic void m_clear();
      pipe.delete();
      for (int k = 0; k < DEPTH; k++) pipe.push_back('{valid: 1'b0, dest: 0, lat: 1});
   endfunction

   // Youngest producer decides: forward if it has reached its latency, else stall.
   function automatic void m_lookup(input int src, input bit rd, output int sel, output bit unready);
      sel = 0;
      unready = 1'b0;
      if (!rd) return;
      for (int k = 1; k < DEPTH; k++) begin
         if (pipe[k].valid && pipe[k].dest == src) begin
            if (k >= pipe[k].lat) sel = k;
            else unready = 1'b1;
            return;
         end
      end
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int es1, es2, sat_max;
      bit un1, un2, exp_stall;
      int cnt_max;

      idle_all();
      sd[0] = 16'hDEAD; sd[1] = 16'h1234; sd[2] = 16'hBEEF;
      pack_sd();
      @(negedge clk);
      do_reset();
      #1;
      check("reset sel1",  32'(bus.fwd1_sel), 0);
      check("reset sel2",  32'(bus.fwd2_sel), 0);
      check("reset data1", 32'(bus.fwd1_data), 0);
      check("reset data2", 32'(bus.fwd2_data), 0);
      check("reset stall", 32'(bus.stall), 0);
      check("reset scyc",  32'(bus.stall_cycles), 0);
      check("reset fev",   32'(bus.fwd_events), 0);

      //              adv fl idv idw dst lat  s1 u1 s2 u2  e1 e2 es  sc fe
      vecs.push_back(mk(1, 0, 1, 1, 1, 1,   0, 0, 0, 0,  0, 0, 0,  0, 0)); // ADD R1
      vecs.push_back(mk(1, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  0, 0));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   1, 1, 0, 0,  1, 0, 0,  0, 0)); // fwd entry 1
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  0, 1));
      vecs.push_back(mk(1, 0, 1, 1, 2, 2,   0, 0, 0, 0,  0, 0, 0,  0, 1)); // LDR R2
      vecs.push_back(mk(1, 0, 1, 1, 5, 1,   0, 0, 0, 0,  0, 0, 0,  0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 2, 1,  0, 0, 1,  0, 1)); // load-use stall
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 2, 1,  0, 2, 0,  1, 1)); // fwd entry 2
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   5, 1, 2, 1,  1, 0, 0,  1, 2)); // R2 retired
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   5, 1, 0, 0,  2, 0, 0,  1, 3));
      vecs.push_back(mk(1, 0, 1, 1, 3, 1,   0, 0, 0, 0,  0, 0, 0,  1, 4)); // R3 twice
      vecs.push_back(mk(1, 0, 1, 1, 3, 1,   0, 0, 0, 0,  0, 0, 0,  1, 4));
      vecs.push_back(mk(1, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  1, 4));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   3, 1, 3, 0,  1, 0, 0,  1, 4)); // youngest wins
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   3, 0, 0, 0,  0, 0, 0,  1, 5)); // use1 = 0
      vecs.push_back(mk(1, 0, 1, 1, 4, 2,   0, 0, 0, 0,  0, 0, 0,  1, 5)); // LDR R4
      vecs.push_back(mk(1, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  1, 5));
      vecs.push_back(mk(1, 1, 0, 0, 0, 1,   4, 1, 0, 0,  0, 0, 1,  1, 5)); // flush in stall
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   4, 1, 0, 0,  0, 0, 0,  1, 5));
      vecs.push_back(mk(1, 0, 1, 1, 6, 2,   0, 0, 0, 0,  0, 0, 0,  1, 5)); // LDR R6
      vecs.push_back(mk(1, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  1, 5));
      vecs.push_back(mk(0, 0, 0, 0, 0, 1,   6, 1, 0, 0,  0, 0, 1,  1, 5)); // frozen stall
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   6, 1, 0, 0,  0, 0, 1,  1, 5));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   6, 1, 0, 0,  2, 0, 0,  2, 5));
      vecs.push_back(mk(1, 0, 1, 1, 7, 0,   0, 0, 0, 0,  0, 0, 0,  2, 6)); // lat 0 -> 1
      vecs.push_back(mk(1, 0, 1, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  2, 6));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 7, 1,  0, 1, 0,  2, 6));
      vecs.push_back(mk(1, 0, 0, 0, 0, 1,   0, 0, 0, 0,  0, 0, 0,  2, 7));

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d sel1", i),  32'(bus.fwd1_sel), 32'(vecs[i].e1));
         check($sformatf("v%0d sel2", i),  32'(bus.fwd2_sel), 32'(vecs[i].e2));
         check($sformatf("v%0d data1", i), 32'(bus.fwd1_data),
               (vecs[i].e1 == 0) ? 32'd0 : 32'(sd[vecs[i].e1]));
         check($sformatf("v%0d data2", i), 32'(bus.fwd2_data),
               (vecs[i].e2 == 0) ? 32'd0 : 32'(sd[vecs[i].e2]));
         check($sformatf("v%0d stall", i), 32'(bus.stall), 32'(vecs[i].es));
         check($sformatf("v%0d scyc", i),  32'(bus.stall_cycles), 32'(vecs[i].esc));
         check($sformatf("v%0d fev", i),   32'(bus.fwd_events), 32'(vecs[i].efe));
         @(negedge clk);
      end

      // ---------------- random run against the model ----------------
      idle_all();
      do_reset();
      m_clear();
      m_sc = 0;
      m_fe = 0;
      cnt_max = (1 << CNT_W) - 1;
      for (int c = 0; c < 800; c++) begin
         rst          = ($urandom_range(0, 99) == 0);
         bus.advance  = ($urandom_range(0, 9) != 0);
         bus.flush    = ($urandom_range(0, 24) == 0);
         bus.id_valid = ($urandom_range(0, 4) != 0);
         bus.id_wr    = ($urandom_range(0, 3) != 0);
         bus.id_dest  = REG_W'($urandom_range(0, 3));
         bus.id_lat   = SEL_W'($urandom_range(0, DEPTH));
         bus.ex_src1  = REG_W'($urandom_range(0, 3));
         bus.ex_src2  = REG_W'($urandom_range(0, 3));
         bus.ex_use1  = ($urandom_range(0, 3) != 0);
         bus.ex_use2  = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < DEPTH; k++) sd[k] = DATA_W'($urandom);
         pack_sd();
         #1;
         m_lookup(int'(bus.ex_src1), bus.ex_use1, es1, un1);
         m_lookup(int'(bus.ex_src2), bus.ex_use2, es2, un2);
         exp_stall = un1 | un2;
         check($sformatf("r%0d sel1", c),  32'(bus.fwd1_sel), 32'(es1));
         check($sformatf("r%0d sel2", c),  32'(bus.fwd2_sel), 32'(es2));
         check($sformatf("r%0d data1", c), 32'(bus.fwd1_data), (es1 == 0) ? 32'd0 : 32'(sd[es1]));
         check($sformatf("r%0d data2", c), 32'(bus.fwd2_data), (es2 == 0) ? 32'd0 : 32'(sd[es2]));
         check($sformatf("r%0d stall", c), 32'(bus.stall), 32'(exp_stall));
         check($sformatf("r%0d scyc", c),  32'(bus.stall_cycles), 32'(m_sc));
         check($sformatf("r%0d fev", c),   32'(bus.fwd_events), 32'(m_fe));
         @(posedge clk);
         if (rst) begin
            m_clear();
            m_sc = 0;
            m_fe = 0;
         end else begin
            if (bus.advance && exp_stall && !bus.flush && m_sc < cnt_max) m_sc++;
            if (bus.advance && !exp_stall && (es1 != 0 || es2 != 0) && m_fe < cnt_max) m_fe++;
            if (bus.flush) begin
               m_clear();
            end else if (bus.advance) begin
               if (exp_stall) begin
                  pipe.insert(1, '{valid: 1'b0, dest: 0, lat: 1});
               end else begin
                  pipe.push_front('{valid: bus.id_valid & bus.id_wr,
                                    dest:  int'(bus.id_dest),
                                    lat:   (bus.id_lat == 0) ? 1 : int'(bus.id_lat)});
               end
               void'(pipe.pop_back());
            end
         end
         @(negedge clk);
      end

      // ---------------- saturation and reset mid-stall (DEPTH 32, CNT_W 4) ----------------
      idle_all();
      do_reset();
      sat_max = (1 << S_CNT_W) - 1;
      sbus.advance  = 1'b1;
      sbus.id_valid = 1'b1;
      sbus.id_wr    = 1'b1;
      sbus.id_dest  = REG_W'(2);
      sbus.id_lat   = S_SEL_W'(31);
      @(negedge clk);
      sbus.id_wr    = 1'b0;
      sbus.id_dest  = '0;
      sbus.id_lat   = S_SEL_W'(1);
      @(negedge clk);
      sbus.id_valid = 1'b0;
      sbus.ex_src1  = REG_W'(2);
      sbus.ex_use1  = 1'b1;
      #1;
      check("sat start stall", 32'(sbus.stall), 1);
      check("sat start scyc",  32'(sbus.stall_cycles), 0);
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         #1;
         check($sformatf("sat%0d stall", i), 32'(sbus.stall), 1);
         check($sformatf("sat%0d scyc", i),  32'(sbus.stall_cycles), 32'((i < sat_max) ? i : sat_max));
      end
      check("sat fev", 32'(sbus.fwd_events), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst stall", 32'(sbus.stall), 0);
      check("rst scyc",  32'(sbus.stall_cycles), 0);
      check("rst fev",   32'(sbus.fwd_events), 0);
      check("rst sel1",  32'(sbus.fwd1_sel), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
